// File: rtl/gyruss_sprite_scanner_pkg.sv
// Purpose: shared constants, FSM encoding and descriptor layout for the sprite line scanner.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package gyruss_sprite_scanner_pkg;

    // Default scan geometry
    localparam int         DEF_NUM_SPR      = 64;
    localparam int         DEF_MAX_PER_LINE = 24;
    localparam int         DEF_SPR_H        = 16;
    localparam logic [8:0] DEF_SCAN_H       = 9'd0;

    // Byte offsets inside a 4-byte sprite entry
    localparam logic [1:0] OFS_X    = 2'd0;
    localparam logic [1:0] OFS_Y    = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_CODE = 2'd3;

    // Attribute byte bit positions
    localparam int ATTR_FLIPY   = 7;
    localparam int ATTR_FLIPX   = 6;
    localparam int ATTR_PAL_MSB = 3;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RD_Y = 4'd1,
        S_CHK  = 4'd2,
        S_RD_X = 4'd3,
        S_RD_A = 4'd4,
        S_RD_C = 4'd5,
        S_PUSH = 4'd6,
        S_NEXT = 4'd7,
        S_DONE = 4'd8
    } scan_state_t;

    // One renderer descriptor as it travels through the FIFO
    typedef struct packed {
        logic [7:0] x;
        logic [3:0] row;
        logic [7:0] attr;
        logic [7:0] code;
    } spr_desc_t;

    // Sprite RAM address of byte 'ofs' of entry 'idx'
    function automatic logic [7:0] spr_addr(input logic [5:0] idx, input logic [1:0] ofs);
        return {idx, ofs};
    endfunction

endpackage

// File: rtl/gyruss_spr_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO with flush, any depth.
// Latency: a pushed word is visible at dout the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; flush beats push and pop.
module gyruss_spr_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 24,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the outputs are clean after reset/flush
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; flush returns to the empty state
    always_ff @(posedge MCLK) begin
        if (!RESET_N || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge MCLK) begin
        if (RESET_N && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gyruss_sprite_scanner.sv
// Purpose: per-line search of sprite work RAM for entries covering line PV+1, queueing one descriptor per hit.
// Latency: LINE_GO one cycle after PH reaches SCAN_H; 3 cycles per miss, 7 per hit, SCAN_DONE after the last entry.
// Backpressure: FIFO depth equals the per-line hit cap, so the scan never stalls; OUT_* hold while OUT_RDY=0.
module gyruss_sprite_scanner
    import gyruss_sprite_scanner_pkg::*;
#(
    parameter int         NUM_SPR      = DEF_NUM_SPR,
    parameter int         MAX_PER_LINE = DEF_MAX_PER_LINE,
    parameter int         SPR_H        = DEF_SPR_H,
    parameter logic [8:0] SCAN_H       = DEF_SCAN_H
) (
    input  logic       MCLK,
    input  logic       RESET_N,
    input  logic [8:0] PH,
    input  logic [8:0] PV,
    output logic [7:0] SPAA,
    input  logic [7:0] SPAD,
    output logic       OUT_VLD,
    input  logic       OUT_RDY,
    output logic [7:0] OUT_X,
    output logic [3:0] OUT_ROW,
    output logic [7:0] OUT_ATTR,
    output logic [7:0] OUT_CODE,
    output logic       LINE_GO,
    output logic       SCAN_DONE,
    output logic [4:0] HIT_CNT,
    output logic       OVF
);

    localparam int CW = $clog2(MAX_PER_LINE + 1);

    scan_state_t state;
    scan_state_t state_nxt;

    logic [8:0]    ph_q;
    logic          trig;
    logic [5:0]    idx;
    logic [5:0]    idx_nxt;
    logic [7:0]    spaa_q;
    logic [7:0]    spaa_nxt;
    logic [7:0]    tv;
    logic [7:0]    dy;
    logic          spr_hit;
    logic [3:0]    dy_q;
    logic [7:0]    x_q;
    logic [7:0]    attr_q;
    logic [3:0]    row_calc;
    logic          last_idx;
    logic          room;
    logic          line_go_q;
    logic [4:0]    hit_cnt;
    logic          ovf_q;

    spr_desc_t     push_desc;
    spr_desc_t     head_desc;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_sig;

    // PH arriving at SCAN_H (edge, not level) starts or restarts the line scan
    assign trig      = (PH == SCAN_H) && (ph_q != SCAN_H);
    assign dy        = tv - SPAD;
    assign spr_hit   = (dy < 8'(SPR_H));
    assign last_idx  = (idx == 6'(NUM_SPR - 1));
    assign room      = (hit_cnt < 5'(MAX_PER_LINE));
    assign row_calc  = attr_q[ATTR_FLIPY] ? (4'(SPR_H - 1) - dy_q) : dy_q;
    // Code byte is on SPAD during PUSH, so it goes straight into the FIFO
    assign push_desc = {x_q, row_calc, attr_q, SPAD};
    assign fifo_push = (state == S_PUSH) && room;

    assign SPAA      = spaa_q;
    assign LINE_GO   = line_go_q;
    assign SCAN_DONE = (state == S_DONE);
    assign HIT_CNT   = hit_cnt;
    assign OVF       = ovf_q;
    assign OUT_VLD   = !fifo_empty;
    assign OUT_X     = head_desc.x;
    assign OUT_ROW   = head_desc.row;
    assign OUT_ATTR  = head_desc.attr;
    assign OUT_CODE  = head_desc.code;
    assign unused_sig = ^{fifo_full, fifo_count, PV[8]};

    // State register
    always_ff @(posedge MCLK) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state, next entry index and the RAM address for the coming state
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        spaa_nxt  = spaa_q;
        case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_RD_Y:  state_nxt = S_CHK;
            S_CHK:   state_nxt = spr_hit ? S_RD_X : S_NEXT;
            S_RD_X:  state_nxt = S_RD_A;
            S_RD_A:  state_nxt = S_RD_C;
            S_RD_C:  state_nxt = S_PUSH;
            S_PUSH:  state_nxt = S_NEXT;
            S_NEXT:  state_nxt = last_idx ? S_DONE : S_RD_Y;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (state == S_NEXT && !last_idx) idx_nxt = idx + 6'd1;
        if (trig) begin
            state_nxt = S_RD_Y;
            idx_nxt   = '0;
        end
        // Address is registered so it is stable for the whole state that issues it
        case (state_nxt)
            S_RD_Y:  spaa_nxt = spr_addr(idx_nxt, OFS_Y);
            S_RD_X:  spaa_nxt = spr_addr(idx, OFS_X);
            S_RD_A:  spaa_nxt = spr_addr(idx, OFS_ATTR);
            S_RD_C:  spaa_nxt = spr_addr(idx, OFS_CODE);
            default: ;
        endcase
    end

    // Trigger history, line setup, byte capture and hit/overflow bookkeeping
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            ph_q      <= SCAN_H;
            line_go_q <= 1'b0;
            spaa_q    <= '0;
            idx       <= '0;
            tv        <= '0;
            dy_q      <= '0;
            x_q       <= '0;
            attr_q    <= '0;
            hit_cnt   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            ph_q      <= PH;
            line_go_q <= trig;
            spaa_q    <= spaa_nxt;
            idx       <= idx_nxt;
            if (trig) begin
                tv      <= PV[7:0] + 8'd1;
                hit_cnt <= '0;
                ovf_q   <= 1'b0;
            end else begin
                case (state)
                    S_CHK:  dy_q   <= dy[3:0];
                    S_RD_A: x_q    <= SPAD;
                    S_RD_C: attr_q <= SPAD;
                    S_PUSH: begin
                        if (room) hit_cnt <= hit_cnt + 5'd1;
                        else      ovf_q   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    gyruss_spr_fifo #(
        .WIDTH ($bits(spr_desc_t)),
        .DEPTH (MAX_PER_LINE)
    ) u_fifo (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .flush   (trig),
        .push    (fifo_push),
        .din     (push_desc),
        .pop     (OUT_RDY),
        .dout    (head_desc),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_gyruss_sprite_scanner.sv
// Purpose: directed self-checking bench for the sprite line scanner with a behavioural sprite RAM.
// Latency: RAM model returns SPAD one MCLK after SPAA.
// Backpressure: OUT_RDY driven by the sequence (held low, pulsed, or random).
module tb_gyruss_sprite_scanner;

    logic       MCLK = 1'b0;
    logic       RESET_N;
    logic [8:0] PH;
    logic [8:0] PV;
    logic [7:0] SPAA;
    logic [7:0] SPAD;
    logic       OUT_VLD;
    logic       OUT_RDY;
    logic [7:0] OUT_X;
    logic [3:0] OUT_ROW;
    logic [7:0] OUT_ATTR;
    logic [7:0] OUT_CODE;
    logic       LINE_GO;
    logic       SCAN_DONE;
    logic [4:0] HIT_CNT;
    logic       OVF;

    logic [7:0]  ram [256];
    logic [27:0] got [$];
    logic [27:0] exp5 [6];
    logic [27:0] hold_val;
    logic        held;
    int          tests = 0;
    int          fails = 0;

    gyruss_sprite_scanner dut (
        .MCLK      (MCLK),
        .RESET_N   (RESET_N),
        .PH        (PH),
        .PV        (PV),
        .SPAA      (SPAA),
        .SPAD      (SPAD),
        .OUT_VLD   (OUT_VLD),
        .OUT_RDY   (OUT_RDY),
        .OUT_X     (OUT_X),
        .OUT_ROW   (OUT_ROW),
        .OUT_ATTR  (OUT_ATTR),
        .OUT_CODE  (OUT_CODE),
        .LINE_GO   (LINE_GO),
        .SCAN_DONE (SCAN_DONE),
        .HIT_CNT   (HIT_CNT),
        .OVF       (OVF)
    );

    always #5 MCLK = ~MCLK;

    // Synchronous-read sprite RAM
    always @(posedge MCLK) SPAD <= ram[SPAA];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, logging any descriptor handed over at this edge
    task automatic tick();
        if (OUT_VLD === 1'b1 && OUT_RDY === 1'b1) got.push_back({OUT_X, OUT_ROW, OUT_ATTR, OUT_CODE});
        @(posedge MCLK);
        #1;
    endtask

    task automatic set_ent(input int n, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] a, input logic [7:0] c);
        ram[4*n]     = x;
        ram[4*n + 1] = y;
        ram[4*n + 2] = a;
        ram[4*n + 3] = c;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 64; i++) set_ent(i, 8'h00, 8'hF0, 8'h00, 8'h00);
    endtask

    // Pulse PH to SCAN_H; returns in the LINE_GO cycle
    task automatic trigger(input logic [7:0] pv);
        OUT_RDY = 1'b0;
        PV = {1'b0, pv};
        PH = 9'd0;
        tick();
        PH = 9'd100;
        check("line_go", {31'd0, LINE_GO}, 32'd1);
        check("vld_at_go", {31'd0, OUT_VLD}, 32'd0);
        check("hitcnt_at_go", {27'd0, HIT_CNT}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int c;
        c = 0;
        while (SCAN_DONE !== 1'b1 && c < 600) begin
            tick();
            c++;
        end
        check(tag, c, exp_cyc);
        tick();
        check("done_pulse_len", {31'd0, SCAN_DONE}, 32'd0);
    endtask

    task automatic drain();
        int c;
        c = 0;
        got.delete();
        OUT_RDY = 1'b1;
        while (OUT_VLD === 1'b1 && c < 40) begin
            tick();
            c++;
        end
        OUT_RDY = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_spaa"}, {24'd0, SPAA}, 32'd0);
        check({tag, "_vld"}, {31'd0, OUT_VLD}, 32'd0);
        check({tag, "_desc"}, {4'd0, OUT_X, OUT_ROW, OUT_ATTR, OUT_CODE}, 32'd0);
        check({tag, "_go"}, {31'd0, LINE_GO}, 32'd0);
        check({tag, "_done"}, {31'd0, SCAN_DONE}, 32'd0);
        check({tag, "_hitcnt"}, {27'd0, HIT_CNT}, 32'd0);
        check({tag, "_ovf"}, {31'd0, OVF}, 32'd0);
    endtask

    initial begin
        RESET_N = 1'b0;
        PH      = 9'd100;
        PV      = 9'd0;
        OUT_RDY = 1'b0;
        clear_ram();
        repeat (3) tick();
        check_idle_outputs("reset");
        RESET_N = 1'b1;
        tick();

        // 1: reset while in CHK of entry 1 (entry 0 already pushed)
        set_ent(0, 8'h11, 8'h25, 8'h00, 8'h01);
        trigger(8'h24);
        repeat (8) tick();
        check("pre_rst_hitcnt", {27'd0, HIT_CNT}, 32'd1);
        check("pre_rst_vld", {31'd0, OUT_VLD}, 32'd1);
        check("pre_rst_spaa", {24'd0, SPAA}, 32'd5);
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        check_idle_outputs("midscan_rst");
        repeat (20) tick();
        check_idle_outputs("post_rst_idle");

        // 2: single hit at entry 5
        clear_ram();
        set_ent(5, 8'h40, 8'h20, 8'h03, 8'h7A);
        trigger(8'h24);
        wait_done("t2_scan_cycles", 196);
        check("t2_hitcnt", {27'd0, HIT_CNT}, 32'd1);
        check("t2_ovf", {31'd0, OVF}, 32'd0);
        check("t2_vld", {31'd0, OUT_VLD}, 32'd1);
        check("t2_x", {24'd0, OUT_X}, 32'h40);
        check("t2_row", {28'd0, OUT_ROW}, 32'd5);
        check("t2_attr", {24'd0, OUT_ATTR}, 32'h03);
        check("t2_code", {24'd0, OUT_CODE}, 32'h7A);
        drain();
        check("t2_count", got.size(), 32'd1);
        check("t2_empty", {31'd0, OUT_VLD}, 32'd0);

        // 3a: Y wrap with flip-Y (TV=3, Y=0xFA, dy=9 -> row 6)
        clear_ram();
        set_ent(9,  8'h11, 8'hFA, 8'h80, 8'h22);
        set_ent(10, 8'h33, 8'h10, 8'h00, 8'h44);
        set_ent(11, 8'h55, 8'h11, 8'h00, 8'h66);
        trigger(8'h02);
        wait_done("t3a_scan_cycles", 196);
        check("t3a_hitcnt", {27'd0, HIT_CNT}, 32'd1);
        check("t3a_desc", {4'd0, OUT_X, OUT_ROW, OUT_ATTR, OUT_CODE}, {4'd0, 8'h11, 4'd6, 8'h80, 8'h22});
        drain();
        // 3b: TV=0x20: dy=16 misses, dy=15 hits with row 15
        trigger(8'h1F);
        wait_done("t3b_scan_cycles", 196);
        check("t3b_hitcnt", {27'd0, HIT_CNT}, 32'd1);
        check("t3b_desc", {4'd0, OUT_X, OUT_ROW, OUT_ATTR, OUT_CODE}, {4'd0, 8'h55, 4'd15, 8'h00, 8'h66});
        drain();

        // 4: 30 hits, only the first 24 kept
        clear_ram();
        for (int i = 0; i < 30; i++) set_ent(i, 8'(i), 8'h50, 8'h00, 8'(8'h80 + i));
        trigger(8'h50);
        wait_done("t4_scan_cycles", 312);
        check("t4_hitcnt", {27'd0, HIT_CNT}, 32'd24);
        check("t4_ovf", {31'd0, OVF}, 32'd1);
        drain();
        check("t4_count", got.size(), 32'd24);
        for (int i = 0; i < 24 && i < got.size(); i++)
            check("t4_desc", {4'd0, got[i]}, {4'd0, 8'(i), 4'd1, 8'h00, 8'(8'h80 + i)});
        check("t4_hitcnt_held", {27'd0, HIT_CNT}, 32'd24);
        check("t4_ovf_held", {31'd0, OVF}, 32'd1);

        // 5: stalled for the whole scan, then random backpressure
        clear_ram();
        set_ent(2,  8'h12, 8'h31, 8'h00, 8'h02);
        set_ent(7,  8'h17, 8'h2A, 8'h40, 8'h07);
        set_ent(8,  8'h18, 8'h22, 8'h0F, 8'h08);
        set_ent(20, 8'h24, 8'h25, 8'h00, 8'h14);
        set_ent(30, 8'h2E, 8'h21, 8'h00, 8'h1E);
        set_ent(31, 8'h2F, 8'h32, 8'h00, 8'h1F);
        set_ent(40, 8'h38, 8'h30, 8'h80, 8'h28);
        set_ent(63, 8'h4F, 8'h28, 8'hC5, 8'h3F);
        exp5[0] = {8'h12, 4'd0,  8'h00, 8'h02};
        exp5[1] = {8'h17, 4'd7,  8'h40, 8'h07};
        exp5[2] = {8'h18, 4'd15, 8'h0F, 8'h08};
        exp5[3] = {8'h24, 4'd12, 8'h00, 8'h14};
        exp5[4] = {8'h38, 4'd14, 8'h80, 8'h28};
        exp5[5] = {8'h4F, 4'd6,  8'hC5, 8'h3F};
        trigger(8'h30);
        wait_done("t5_scan_cycles", 216);
        check("t5_hitcnt", {27'd0, HIT_CNT}, 32'd6);
        check("t5_head", {4'd0, OUT_X, OUT_ROW, OUT_ATTR, OUT_CODE}, {4'd0, exp5[0]});
        got.delete();
        for (int cyc = 0; cyc < 300 && got.size() < 6; cyc++) begin
            OUT_RDY  = 1'($urandom_range(0, 1));
            held     = OUT_VLD && !OUT_RDY;
            hold_val = {OUT_X, OUT_ROW, OUT_ATTR, OUT_CODE};
            tick();
            if (held) check("t5_stall_stable", {4'd0, OUT_X, OUT_ROW, OUT_ATTR, OUT_CODE}, {4'd0, hold_val});
        end
        OUT_RDY = 1'b0;
        tick();
        check("t5_count", got.size(), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check("t5_desc", {4'd0, got[i]}, {4'd0, exp5[i]});
        check("t5_empty", {31'd0, OUT_VLD}, 32'd0);

        // 6: new trigger with 3 descriptors still queued
        clear_ram();
        set_ent(1, 8'h01, 8'h61, 8'h00, 8'hA1);
        set_ent(2, 8'h02, 8'h61, 8'h00, 8'hA2);
        set_ent(3, 8'h03, 8'h61, 8'h00, 8'hA3);
        trigger(8'h60);
        wait_done("t6a_scan_cycles", 204);
        check("t6_hitcnt_before", {27'd0, HIT_CNT}, 32'd3);
        check("t6_vld_before", {31'd0, OUT_VLD}, 32'd1);
        clear_ram();
        set_ent(50, 8'h99, 8'h70, 8'h01, 8'h55);
        trigger(8'h70);
        tick();
        check("t6_vld_after_go", {31'd0, OUT_VLD}, 32'd0);
        wait_done("t6b_scan_cycles", 195);
        check("t6_hitcnt_after", {27'd0, HIT_CNT}, 32'd1);
        drain();
        check("t6_count", got.size(), 32'd1);
        if (got.size() > 0) check("t6_desc", {4'd0, got[0]}, {4'd0, 8'h99, 4'd1, 8'h01, 8'h55});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
